// File: rtl/delay_tdc_pkg.sv
// Shared types and width helpers for the delay-line time-to-digital converter.
package delay_tdc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SYNC    = 3'd3,
    ST_ACCUM   = 3'd4,
    ST_RECOVER = 3'd5,
    ST_RESULT  = 3'd6
  } tdc_state_e;

  // Per-sample count must hold 0..num_taps inclusive.
  function automatic int tdc_cnt_w(input int num_taps);
    return $clog2(num_taps + 1);
  endfunction

endpackage

// File: rtl/SB_LUT4.sv
// Behavioural model of the iCE40 4-input LUT cell; the vendor cell library
// replaces it in the FPGA build, so it belongs only in the simulation file list.
module SB_LUT4 #(
  parameter logic [15:0] LUT_INIT = 16'h0000
) (
  output logic O,
  input  logic I0,
  input  logic I1,
  input  logic I2,
  input  logic I3
);

  assign O = LUT_INIT[{I3, I2, I1, I0}];

endmodule

// File: rtl/delay_tap_chain.sv
// Tapped chain of LUT buffers; each LUT output is one tap of the delay line.
module delay_tap_chain #(
  parameter int NUM_TAPS = 64
) (
  input  logic                line_in,
  output logic [NUM_TAPS-1:0] taps
);

  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_stage
    (* keep *) logic buf_out;
    logic            buf_in;

    // Each stage reads the previous stage's local net so the chain stays a
    // strict series of cells rather than a self-referencing vector.
    if (g == 0) begin : g_first
      assign buf_in = line_in;
    end else begin : g_next
      assign buf_in = g_stage[g-1].buf_out;
    end

    (* keep *) SB_LUT4 #(
      .LUT_INIT(16'd2)
    ) u_buf (
      .O (buf_out),
      .I0(buf_in),
      .I1(1'b0),
      .I2(1'b0),
      .I3(1'b0)
    );

    assign taps[g] = buf_out;
  end

endmodule

// File: rtl/delay_tdc.sv
// Delay-line TDC: launches an edge, captures the tap chain, decodes the
// thermometer code and accumulates 2^AVG_LOG2 samples behind a valid/ready result.
module delay_tdc
  import delay_tdc_pkg::*;
#(
  parameter  int NUM_TAPS       = 64,
  parameter  int AVG_LOG2       = 3,
  parameter  int RECOVER_CYCLES = 4,
  localparam int CNT_W          = tdc_cnt_w(NUM_TAPS),
  localparam int RES_W          = CNT_W + AVG_LOG2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic [RES_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overflow
);

  localparam int SMP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int REC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);
  localparam logic [REC_W-1:0] REC_LAST = REC_W'(RECOVER_CYCLES - 1);

  // Leading run of ones from tap 0: the first 0 ends the run, later 1s are bubbles.
  function automatic logic [CNT_W-1:0] lead_run(input logic [NUM_TAPS-1:0] t);
    logic [CNT_W-1:0] n;
    n = CNT_W'(NUM_TAPS);
    for (int i = NUM_TAPS - 1; i >= 0; i--) begin
      if (!t[i]) n = CNT_W'(i);
    end
    return n;
  endfunction

  tdc_state_e          st_q;
  logic                launch_q;
  logic                pol_q;
  logic [RES_W-1:0]    acc_q;
  logic                ovf_q;
  logic [SMP_W-1:0]    smp_q;
  logic [REC_W-1:0]    rec_q;
  logic                busy_q;
  logic                valid_q;
  logic [NUM_TAPS-1:0] taps_w;
  logic [NUM_TAPS-1:0] cap_p1_q;
  logic [NUM_TAPS-1:0] cap_p2_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [RES_W-1:0]    acc_d;
  logic                sat_d;

  delay_tap_chain #(
    .NUM_TAPS(NUM_TAPS)
  ) u_chain (
    .line_in(launch_q),
    .taps   (taps_w)
  );

  // Stage 1 catches the raw chain (may go metastable); stage 2 resolves it and
  // flips falling-edge samples so a reached tap always reads 1.
  always_ff @(posedge clk) begin
    if (st_q == ST_CAPTURE) cap_p1_q <= taps_w;
    if (st_q == ST_SYNC)    cap_p2_q <= cap_p1_q ^ {NUM_TAPS{~pol_q}};
  end

  assign cnt_d = lead_run(cap_p2_q);
  assign sat_d = (cnt_d == CNT_W'(NUM_TAPS));
  assign acc_d = acc_q + RES_W'(cnt_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= ST_IDLE;
      launch_q <= 1'b0;
      pol_q    <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      smp_q    <= '0;
      rec_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          if (start) begin
            st_q   <= ST_LAUNCH;
            busy_q <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          launch_q <= ~launch_q;
          pol_q    <= ~launch_q;
          st_q     <= ST_CAPTURE;
        end
        ST_CAPTURE: st_q <= ST_SYNC;
        ST_SYNC:    st_q <= ST_ACCUM;
        ST_ACCUM: begin
          acc_q <= acc_d;
          if (sat_d) ovf_q <= 1'b1;
          rec_q <= '0;
          st_q  <= ST_RECOVER;
        end
        ST_RECOVER: begin
          if (rec_q == REC_LAST) begin
            if (smp_q == SMP_LAST) begin
              st_q    <= ST_RESULT;
              valid_q <= 1'b1;
            end else begin
              smp_q <= smp_q + 1'b1;
              st_q  <= ST_LAUNCH;
            end
          end else begin
            rec_q <= rec_q + 1'b1;
          end
        end
        ST_RESULT: begin
          if (result_ready) begin
            valid_q <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            smp_q   <= '0;
            if (start) begin
              st_q <= ST_LAUNCH;
            end else begin
              st_q   <= ST_IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: begin
          st_q    <= ST_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign result       = acc_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_delay_tdc.sv
// Randomised bench for delay_tdc: taps are forced to a thermometer pattern per
// launch and results are compared with sums computed from the chosen reach counts.
module tb_delay_tdc;

  localparam int N   = 64;
  localparam int A   = 3;
  localparam int R   = 4;
  localparam int P   = 4 + R;
  localparam int NS  = 1 << A;
  localparam int RW  = 7 + A;
  localparam int N6  = 8;
  localparam int RW6 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          result_ready = 1'b0;
  logic          busy, result_valid, overflow;
  logic [RW-1:0] result;

  logic           start6 = 1'b0;
  logic           ready6 = 1'b0;
  logic           busy6, valid6, ovf6;
  logic [RW6-1:0] result6;

  delay_tdc #(
    .NUM_TAPS(N), .AVG_LOG2(A), .RECOVER_CYCLES(R)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .result(result),
    .result_valid(result_valid), .result_ready(result_ready), .overflow(overflow)
  );

  delay_tdc #(
    .NUM_TAPS(N6), .AVG_LOG2(0), .RECOVER_CYCLES(4)
  ) dut6 (
    .clk(clk), .reset(reset), .start(start6), .busy(busy6), .result(result6),
    .result_valid(valid6), .result_ready(ready6), .overflow(ovf6)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference state: reach count per sample and current launch level.
  int          ks[NS];
  logic        use_fixed = 1'b0;
  logic [N-1:0] fixed_pat = '0;
  logic        lvl = 1'b0;
  logic        lvl6 = 1'b0;
  logic [N-1:0] tap_force;

  function automatic logic [N-1:0] make_pat(input int k);
    logic [N-1:0] p;
    p = {$urandom, $urandom};
    for (int i = 0; i < k; i++) p[i] = 1'b1;
    if (k < N) p[k] = 1'b0;
    return p;
  endfunction

  function automatic int exp_sum();
    int s = 0;
    for (int j = 0; j < NS; j++) s += ks[j];
    return s;
  endfunction

  function automatic logic exp_ovf();
    logic o = 1'b0;
    for (int j = 0; j < NS; j++) if (ks[j] == N) o = 1'b1;
    return o;
  endfunction

  task automatic set_sample(input int j);
    logic [N-1:0] pat;
    pat = use_fixed ? fixed_pat : make_pat(ks[j]);
    lvl = ~lvl;
    tap_force = lvl ? pat : ~pat;
    force dut.taps_w = tap_force;
  endtask

  // Starts a measurement (also accepting any pending result) at a negedge and
  // returns the start-to-valid latency in clock edges, or aborts via reset.
  task automatic run_meas(input int abort_t, output int lat);
    lat = -1;
    set_sample(0);
    start = 1'b1;
    result_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    result_ready = 1'b0;
    check("busy_after_start", busy, 1);
    check("valid_after_start", result_valid, 0);
    for (int t = 1; t <= NS * P + 10; t++) begin
      start = 1'($urandom_range(0, 1));
      @(posedge clk); @(negedge clk);
      if (t == abort_t) begin
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_valid", result_valid, 0);
        check("abort_result", result, 0);
        check("abort_overflow", overflow, 0);
        reset = 1'b0;
        lvl = 1'b0;
        lat = -2;
        return;
      end
      if (result_valid) begin
        lat = t + 1;
        break;
      end
      if (t % P == 0 && t / P < NS) set_sample(t / P);
    end
    start = 1'b0;
    if (lat < 0) check("valid_timeout", 0, 1);
  endtask

  task automatic check_result(input string tag, input int lat);
    check({tag, "_latency"}, lat, 1 + NS * P);
    check({tag, "_result"}, result, exp_sum());
    check({tag, "_overflow"}, overflow, exp_ovf());
  endtask

  task automatic accept();
    result_ready = 1'b1;
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    result_ready = 1'b0;
    check("accept_valid", result_valid, 0);
    check("accept_busy", busy, 0);
    check("accept_cleared", result, 0);
  endtask

  task automatic run6(input int k, input int pass);
    logic [N6-1:0] pat;
    int lat;
    pat = N6'($urandom);
    for (int i = 0; i < k; i++) pat[i] = 1'b1;
    if (k < N6) pat[k] = 1'b0;
    lvl6 = ~lvl6;
    force dut6.taps_w = lvl6 ? pat : ~pat;
    start6 = 1'b1;
    @(posedge clk); @(negedge clk);
    start6 = 1'b0;
    check($sformatf("p%0d_busy6", pass), busy6, 1);
    lat = -1;
    for (int t = 1; t <= 30; t++) begin
      @(posedge clk); @(negedge clk);
      if (valid6) begin
        lat = t + 1;
        break;
      end
    end
    check($sformatf("p%0d_latency6", pass), lat, 9);
    check($sformatf("p%0d_result6", pass), result6, k);
    check($sformatf("p%0d_overflow6", pass), ovf6, (k == N6) ? 1 : 0);
    check($sformatf("p%0d_launch6", pass), dut6.launch_q, lvl6);
    ready6 = 1'b1;
    @(posedge clk); @(negedge clk);
    ready6 = 1'b0;
    check($sformatf("p%0d_valid6_drop", pass), valid6, 0);
    check($sformatf("p%0d_busy6_drop", pass), busy6, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_result", result, 0);
    check("rst_overflow", overflow, 0);
    check("rst_launch", dut.launch_q, 0);
    check("rst_valid6", valid6, 0);
    reset = 1'b0;
    @(negedge clk);

    // 20 taps reached every sample.
    for (int j = 0; j < NS; j++) ks[j] = 20;
    run_meas(0, lat);
    check_result("t1", lat);
    check("t1_result_abs", result, 160);
    accept();

    // Bubble pattern 1^10,0,1^5,0...
    use_fixed = 1'b1;
    fixed_pat = '0;
    fixed_pat[9:0] = '1;
    fixed_pat[15:11] = '1;
    for (int j = 0; j < NS; j++) ks[j] = 10;
    run_meas(0, lat);
    check_result("t2_bubble", lat);
    check("t2_result_abs", result, 80);
    use_fixed = 1'b0;
    accept();

    // One fully reached sample saturates; then hold without ready.
    for (int j = 0; j < NS; j++) ks[j] = $urandom_range(0, N - 1);
    ks[$urandom_range(0, NS - 1)] = N;
    run_meas(0, lat);
    check_result("t2_sat", lat);
    for (int c = 0; c < 10; c++) begin
      result_ready = 1'b0;
      start = c[0];
      @(posedge clk); @(negedge clk);
      check("t3_hold_valid", result_valid, 1);
      check("t3_hold_result", result, exp_sum());
      check("t3_hold_overflow", overflow, 1);
      check("t3_hold_busy", busy, 1);
    end
    accept();

    // Back-to-back: accept and start in the same cycle, second run has 0 taps.
    for (int j = 0; j < NS; j++) ks[j] = $urandom_range(1, N);
    run_meas(0, lat);
    check_result("t4_first", lat);
    for (int j = 0; j < NS; j++) ks[j] = 0;
    run_meas(0, lat);
    check_result("t4_second", lat);
    accept();

    // Reset in RECOVER of the third sample, then a clean run.
    for (int j = 0; j < NS; j++) ks[j] = $urandom_range(0, N);
    run_meas(2 * P + 5, lat);
    check("t5_aborted", lat, -2);
    check("t5_launch_reset", dut.launch_q, 0);
    for (int j = 0; j < NS; j++) ks[j] = $urandom_range(0, N);
    run_meas(0, lat);
    check_result("t5_clean", lat);
    accept();

    // Random trials with random ready delay.
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < NS; j++)
        ks[j] = ($urandom_range(0, 5) == 0) ? N : $urandom_range(0, N);
      run_meas(0, lat);
      check_result($sformatf("rnd%0d", r), lat);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); @(negedge clk);
        check("rnd_hold_result", result, exp_sum());
      end
      accept();
    end

    // Small instance: one sample per result, polarity alternates per launch.
    run6(N6, 0);
    run6(3, 1);
    run6(N6, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
